// File: rtl/mbyte_add_seq_if.sv
// ---------------------------------------------------------------------------
// mbyte_add_seq_if
// Bundles the request/response handshake of mbyte_add_seq together with the
// link to the shared 8-bit adder.
//   start/sub/a/b          : request from ALU control (master -> slave)
//   busy/done/result/...   : status and result back to ALU control
//   add_op1/add_op2/add_cin: operands driven to the shared adder
//   add_ans                : combinational sum returned by the shared adder
// Modports: master = ALU control / adder side, slave = mbyte_add_seq.
// ---------------------------------------------------------------------------
interface mbyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [7:0]   add_op1;
  logic [7:0]   add_op2;
  logic         add_cin;
  logic [7:0]   add_ans;

  modport master (
    output start, sub, a, b, add_ans,
    input  busy, done, result, cout, ovf, add_op1, add_op2, add_cin
  );

  modport slave (
    input  start, sub, a, b, add_ans,
    output busy, done, result, cout, ovf, add_op1, add_op2, add_cin
  );
endinterface

// File: rtl/mbyte_add_seq.sv
// ---------------------------------------------------------------------------
// mbyte_add_seq
// Byte-serial add/subtract of two (8*NBYTES)-bit operands using one external
// 8-bit adder that has no carry-out. Byte 0 is processed first; the carry
// into each following byte is rebuilt from the operand and sum MSBs.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mbyte_add_seq_if.slave (start/sub/a/b in, busy/done/result/cout/ovf
//         out, add_op1/add_op2/add_cin to the shared adder, add_ans back)
// ---------------------------------------------------------------------------
module mbyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  mbyte_add_seq_if.slave     bus
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sub;
  logic [W-1:0]     r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [7:0]       w_op1;
  logic [7:0]       w_op2;
  logic             w_cin;
  logic             w_accept;
  logic             w_last;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;

  // Carry out of an 8-bit add recovered from the MSBs alone: a carry leaves
  // bit 7 when both operand MSBs are set, or when exactly one is set and the
  // sum MSB came out clear (a carry rippled into bit 7 and out again).
  function automatic logic carry_rebuild(input logic op1_msb,
                                         input logic op2_msb,
                                         input logic ans_msb);
    carry_rebuild = (op1_msb & op2_msb) | ((op1_msb ^ op2_msb) & ~ans_msb);
  endfunction

  // Signed overflow: same-sign operands producing a different-sign sum.
  function automatic logic ovf_detect(input logic op1_msb,
                                      input logic op2_msb,
                                      input logic ans_msb);
    ovf_detect = (op1_msb == op2_msb) && (ans_msb != op1_msb);
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and adder drive
  always_comb begin
    w_state_nxt = r_state;
    w_op1       = 8'h00;
    w_op2       = 8'h00;
    w_cin       = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_op1 = r_a[8*r_idx +: 8];
        w_op2 = r_sub ? ~r_b[8*r_idx +: 8] : r_b[8*r_idx +: 8];
        w_cin = r_carry;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_carry_nxt = carry_rebuild(w_op1[7], w_op2[7], bus.add_ans[7]);
  assign w_ovf_nxt   = ovf_detect(w_op1[7], w_op2[7], bus.add_ans[7]);

  // Operand capture and per-byte result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_sub    <= bus.sub;
        r_result <= '0;
        r_idx    <= '0;
        // Subtraction is a + ~b + 1: the +1 enters as the byte-0 carry.
        r_carry  <= bus.sub;
      end else if (r_state == S_RUN) begin
        r_result[8*r_idx +: 8] <= bus.add_ans;
        r_carry                <= w_carry_nxt;
        if (w_last) begin
          r_idx  <= '0;
          r_cout <= w_carry_nxt;
          r_ovf  <= w_ovf_nxt;
          r_done <= 1'b1;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.cout    = r_cout;
  assign bus.ovf     = r_ovf;
  assign bus.add_op1 = w_op1;
  assign bus.add_op2 = w_op2;
  assign bus.add_cin = w_cin;

endmodule
